// File: rtl/native_cfg_sequencer_if.sv
// Host command, response and native bridge signals of native_cfg_sequencer.
// slave: the sequencer side; master: the host/bridge side that drives commands and bridge status.
interface native_cfg_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic [DATA_WIDTH-1:0] cmd_mask;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_busy;

    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_busy;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  idle;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
        input  rsp_ready, wr_busy, rd_busy, rd_valid, rd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, idle
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask,
        output rsp_ready, wr_busy, rd_busy, rd_valid, rd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, idle
    );
endinterface

// File: rtl/native_cfg_sequencer.sv
// Buffers write/read/poll commands and issues them one at a time to the native bridge port.
// Define CFG_SEQ_POLL_EN to enable op 10 (masked poll with timeout); without it op 10 is illegal.
module native_cfg_sequencer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic                  i_sys_clk,
    input  logic                  i_reset_n,
    native_cfg_sequencer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        OP_WR   = 2'b00,
        OP_RD   = 2'b01,
        OP_POLL = 2'b10,
        OP_ILL  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_WR,
        GUARD_WR,
        WAIT_WR,
        ISSUE_RD,
        WAIT_RD,
        CHECK,
        RSP
    } state_e;

    state_e state;

    logic [1:0]            fifo_op   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             idle_next;
    op_e              head_op;

    op_e                   cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  err_q;

`ifdef CFG_SEQ_POLL_EN
    logic [DATA_WIDTH-1:0] fifo_mask [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] cmd_mask;
    logic [15:0]           poll_cnt;
`else
    localparam int unsigned unused_poll_limit = POLL_LIMIT;
    logic unused_mask;
    assign unused_mask = ^bus.cmd_mask;
`endif

    // Pointers carry one extra wrap bit, so occupancy is a plain difference.
    assign count      = wr_ptr - rd_ptr;
    assign full       = count[PTR_W];
    assign empty      = (count == '0);
    assign wr_idx     = wr_ptr[PTR_W-1:0];
    assign rd_idx     = rd_ptr[PTR_W-1:0];
    assign push       = bus.cmd_valid && !full;
    assign pop        = (state == IDLE) && !empty;
    assign head_op    = op_e'(fifo_op[rd_idx]);
    assign count_next = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

    assign bus.cmd_ready = !full;

    // Predicts the post-edge state so idle stays a registered output without lagging a cycle.
    assign idle_next = (count_next == '0) &&
                       (((state == IDLE) && empty) ||
                        ((state == WAIT_WR) && !bus.wr_busy) ||
                        ((state == RSP) && bus.rsp_valid && bus.rsp_ready));

    always_ff @(posedge i_sys_clk) begin
        if (push) begin
            fifo_op[wr_idx]   <= bus.cmd_op;
            fifo_addr[wr_idx] <= bus.cmd_addr;
            fifo_data[wr_idx] <= bus.cmd_data;
`ifdef CFG_SEQ_POLL_EN
            fifo_mask[wr_idx] <= bus.cmd_mask;
`endif
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            cmd_op        <= OP_WR;
            cmd_addr      <= '0;
            cmd_data      <= '0;
            rd_data_q     <= '0;
            err_q         <= 1'b0;
            bus.wr_en     <= 1'b0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
            bus.rd_en     <= 1'b0;
            bus.rd_addr   <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.idle      <= 1'b1;
`ifdef CFG_SEQ_POLL_EN
            cmd_mask      <= '0;
            poll_cnt      <= '0;
`endif
        end else begin
            bus.wr_en <= 1'b0;
            bus.rd_en <= 1'b0;
            bus.idle  <= idle_next;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        cmd_op    <= head_op;
                        cmd_addr  <= fifo_addr[rd_idx];
                        cmd_data  <= fifo_data[rd_idx];
                        rd_data_q <= '0;
                        err_q     <= 1'b0;
                        case (head_op)
                            OP_WR: state <= ISSUE_WR;
                            OP_RD: state <= ISSUE_RD;
`ifdef CFG_SEQ_POLL_EN
                            OP_POLL: begin
                                cmd_mask <= fifo_mask[rd_idx];
                                poll_cnt <= 16'(POLL_LIMIT);
                                state    <= ISSUE_RD;
                            end
`endif
                            default: begin
                                err_q <= 1'b1;
                                state <= RSP;
                            end
                        endcase
                    end
                end
                ISSUE_WR: begin
                    if (!bus.wr_busy) begin
                        bus.wr_en   <= 1'b1;
                        bus.wr_addr <= cmd_addr;
                        bus.wr_data <= cmd_data;
                        state       <= GUARD_WR;
                    end
                end
                // The bridge raises busy one cycle after wr_en; skip that cycle.
                GUARD_WR: state <= WAIT_WR;
                WAIT_WR: begin
                    if (!bus.wr_busy) state <= IDLE;
                end
                ISSUE_RD: begin
                    if (!bus.rd_busy) begin
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= cmd_addr;
                        state       <= WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (bus.rd_valid) begin
                        rd_data_q <= bus.rd_data;
`ifdef CFG_SEQ_POLL_EN
                        state     <= (cmd_op == OP_POLL) ? CHECK : RSP;
`else
                        state     <= RSP;
`endif
                    end
                end
`ifdef CFG_SEQ_POLL_EN
                CHECK: begin
                    if ((rd_data_q & cmd_mask) == (cmd_data & cmd_mask)) begin
                        state <= RSP;
                    end else if (poll_cnt == 16'd1) begin
                        poll_cnt <= '0;
                        err_q    <= 1'b1;
                        state    <= RSP;
                    end else begin
                        poll_cnt <= poll_cnt - 16'd1;
                        state    <= ISSUE_RD;
                    end
                end
`endif
                RSP: begin
                    if (!bus.rsp_valid) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= rd_data_q;
                        bus.rsp_err   <= err_q;
                    end else if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.rsp_err   <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_native_cfg_sequencer.sv
// Scoreboard bench for native_cfg_sequencer with a behavioural bridge model.
// Poll expectations follow CFG_SEQ_POLL_EN, matching the RTL build.
`timescale 1ns/1ps
module tb_native_cfg_sequencer;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PLIM  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    native_cfg_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    native_cfg_sequencer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .POLL_LIMIT(PLIM)
    ) dut (
        .i_sys_clk(clk),
        .i_reset_n(rst_n),
        .bus(bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW+DW-1:0] exp_wr[$];
    logic [AW-1:0]    exp_rd[$];
    logic [DW:0]      exp_rsp[$];
    logic [DW-1:0]    rdata_q[$];

    logic wr_bbusy    = 1'b0;
    logic wr_stall    = 1'b0;
    int   wr_busy_cyc = 3;
    int   rd_delay    = 2;
    int   rdv_cyc     = 0;
    int   n_req       = 0;
    int   last_push   = 0;

    assign bus.wr_busy = wr_bbusy | wr_stall;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Bridge write side: busy for a few cycles after each write strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.wr_en) begin
                wr_bbusy = 1'b1;
                repeat (wr_busy_cyc) @(negedge clk);
                wr_bbusy = 1'b0;
            end
        end
    end

    // Bridge read side: busy, then a one-cycle data strobe; abandoned on reset.
    initial begin
        bus.rd_busy  = 1'b0;
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        forever begin
            @(negedge clk);
            bus.rd_valid = 1'b0;
            if (rst_n && bus.rd_en) begin
                logic aborted;
                aborted     = 1'b0;
                bus.rd_busy = 1'b1;
                for (int i = 0; i < rd_delay; i++) begin
                    @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                end
                bus.rd_busy = 1'b0;
                if (!aborted && rst_n) begin
                    bus.rd_valid = 1'b1;
                    bus.rd_data  = (rdata_q.size() != 0) ? rdata_q.pop_front() : 32'hDEAD_BEEF;
                    rdv_cyc      = cyc;
                end
            end
        end
    end

    // Scoreboard: every bridge request and accepted response against the queues.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (bus.wr_en) begin
                    n_req++;
                    if (exp_wr.size() == 0) check("wr_unexpected", 64'(bus.wr_en), 64'd0);
                    else check("wr_req", 64'({bus.wr_addr, bus.wr_data}), 64'(exp_wr.pop_front()));
                end
                if (bus.rd_en) begin
                    n_req++;
                    if (exp_rd.size() == 0) check("rd_unexpected", 64'(bus.rd_en), 64'd0);
                    else check("rd_req", 64'(bus.rd_addr), 64'(exp_rd.pop_front()));
                end
                if (bus.rsp_valid && exp_rsp.size() == 0)
                    check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
                else if (bus.rsp_valid && bus.rsp_ready)
                    check("rsp", 64'({bus.rsp_err, bus.rsp_data}), 64'(exp_rsp.pop_front()));
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [DW-1:0] mask);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        bus.cmd_mask  = mask;
        while (!bus.cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("send_timeout", 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);
        last_push     = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus.idle && exp_wr.size() == 0 && exp_rd.size() == 0 && exp_rsp.size() == 0)
               && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 64'(bus.idle), 64'd1);
        check({tag, "_pending"}, 64'(exp_wr.size() + exp_rd.size() + exp_rsp.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},     64'(bus.wr_en),     64'd0);
        check({tag, "_rd_en"},     64'(bus.rd_en),     64'd0);
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        check({tag, "_rsp_err"},   64'(bus.rsp_err),   64'd0);
        check({tag, "_rsp_data"},  64'(bus.rsp_data),  64'd0);
        check({tag, "_wr_addr"},   64'(bus.wr_addr),   64'd0);
        check({tag, "_wr_data"},   64'(bus.wr_data),   64'd0);
        check({tag, "_rd_addr"},   64'(bus.rd_addr),   64'd0);
        check({tag, "_idle"},      64'(bus.idle),      64'd1);
        check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.cmd_mask  = '0;
        bus.rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write: request two cycles after acceptance, no response.
        exp_wr.push_back({32'h0000_0010, 32'hA5A5_0001});
        send(2'b00, 32'h10, 32'hA5A5_0001, '0);
        n = 0;
        while (!bus.wr_en && n < 20) begin @(negedge clk); n++; end
        check("wr_latency", 64'(cyc - last_push), 64'd2);
        check("wr_busy_not_idle", 64'(bus.idle), 64'd0);
        wait_done("wr");
        check("wr_idle_after_busy", 64'(bus.wr_busy), 64'd0);

        // Read with a slow bridge; response held while not accepted.
        bus.rsp_ready = 1'b0;
        rd_delay = 5;
        rdata_q.push_back(32'h1234_5678);
        exp_rd.push_back(32'h20);
        exp_rsp.push_back({1'b0, 32'h1234_5678});
        send(2'b01, 32'h20, '0, '0);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
        check("rd_rsp_latency", 64'(cyc - rdv_cyc), 64'd2);
        for (int unsigned i = 0; i < 3; i++) begin
            check("rsp_hold_valid", 64'(bus.rsp_valid), 64'd1);
            check("rsp_hold_data", 64'(bus.rsp_data), 64'h1234_5678);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        wait_done("rd");
        rd_delay = 2;

        // Read at the top of the address range.
        rdata_q.push_back(32'hFFFF_0000);
        exp_rd.push_back(32'hFFFF_FFFC);
        exp_rsp.push_back({1'b0, 32'hFFFF_0000});
        send(2'b01, 32'hFFFF_FFFC, 32'h5555_5555, '0);
        wait_done("rd_top");

        // Stalled bridge: one command held in the sequencer, then the FIFO fills.
        wr_busy_cyc = 1;
        wr_stall    = 1'b1;
        for (int unsigned i = 0; i < DEPTH + 1; i++) begin
            exp_wr.push_back({32'h100 + 4 * i, 32'hC0DE_0000 + i});
            send(2'b00, 32'h100 + 4 * i, 32'hC0DE_0000 + i, '0);
            if (i == DEPTH - 1) check("fifo_not_full_7", 64'(bus.cmd_ready), 64'd1);
            if (i == DEPTH)     check("fifo_full_8", 64'(bus.cmd_ready), 64'd0);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fifo_full_hold", 64'(bus.cmd_ready), 64'd0);
        end
        bus.cmd_valid = 1'b0;
        wr_stall = 1'b0;
        exp_wr.push_back({32'h0000_0200, 32'hC0DE_00FF});
        send(2'b00, 32'h200, 32'hC0DE_00FF, '0);
        wait_done("burst");
        wr_busy_cyc = 3;

        // Illegal op: error response, no bridge traffic.
        exp_rsp.push_back({1'b1, 32'h0});
        send(2'b11, 32'h44, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("illegal");

`ifdef CFG_SEQ_POLL_EN
        rdata_q.push_back(32'h0);
        rdata_q.push_back(32'h0);
        rdata_q.push_back(32'h1);
        for (int unsigned i = 0; i < 3; i++) exp_rd.push_back(32'h30);
        exp_rsp.push_back({1'b0, 32'h1});
        send(2'b10, 32'h30, 32'h1, 32'h1);
        wait_done("poll_match");

        rdata_q.push_back(32'hFFFF_FFF1);
        exp_rd.push_back(32'h34);
        exp_rsp.push_back({1'b0, 32'hFFFF_FFF1});
        send(2'b10, 32'h34, 32'h1, 32'h1);
        wait_done("poll_masked");

        for (int unsigned i = 0; i < PLIM; i++) begin
            rdata_q.push_back(32'h0);
            exp_rd.push_back(32'h38);
        end
        exp_rsp.push_back({1'b1, 32'h0});
        send(2'b10, 32'h38, 32'h1, 32'h1);
        wait_done("poll_timeout");
        check("poll_rdata_drained", 64'(rdata_q.size()), 64'd0);
`else
        exp_rsp.push_back({1'b1, 32'h0});
        send(2'b10, 32'h30, 32'h1, 32'h1);
        wait_done("poll_disabled");
`endif

        // Reset while a read is outstanding and three commands are queued.
        rd_delay = 30;
        exp_rd.push_back(32'h40);
        send(2'b01, 32'h40, '0, '0);
        n = 0;
        while (!bus.rd_en && n < 20) begin @(negedge clk); n++; end
        for (int unsigned i = 0; i < 3; i++) send(2'b00, 32'h50 + 4 * i, 32'h77 + i, '0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_wr.delete();
        exp_rd.delete();
        exp_rsp.delete();
        rdata_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_delay = 2;
        base = n_req;
        repeat (20) @(negedge clk);
        check("no_req_after_reset", 64'(n_req - base), 64'd0);
        check("idle_after_reset", 64'(bus.idle), 64'd1);

        exp_wr.push_back({32'h0000_0060, 32'h0BAD_F00D});
        send(2'b00, 32'h60, 32'h0BAD_F00D, '0);
        wait_done("post_reset_wr");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
